// File: rtl/sha_msg_schedule.sv
// sha_msg_schedule: SHA-256 message schedule. Loads 16 words, then emits W[0..63], one per W_ADVANCE.
// W[0] is valid the cycle after the 16th word. `SHA_SCHED_ABORT_EN adds the ABORT input.
module sha_msg_schedule (
  input  logic        CLK,
  input  logic        RESET,
`ifdef SHA_SCHED_ABORT_EN
  input  logic        ABORT,
`endif
  input  logic [31:0] WORD_IN,
  input  logic        WORD_VALID,
  output logic        WORD_READY,
  output logic [31:0] W_OUT,
  output logic        W_VALID,
  input  logic        W_ADVANCE,
  output logic [5:0]  T_IDX,
  output logic [3:0]  LOAD_CNT,
  output logic        BLOCK_DONE
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  t_idx_q, t_idx_d;
  logic [3:0]  load_cnt_q, load_cnt_d;
  logic        abort_w;
  logic [31:0] sig0, sig1, w_next;

`ifdef SHA_SCHED_ABORT_EN
  assign abort_w = ABORT;
`else
  assign abort_w = 1'b0;
`endif

  assign sig0   = {win_q[1][6:0], win_q[1][31:7]} ^ {win_q[1][17:0], win_q[1][31:18]} ^ (win_q[1] >> 3);
  assign sig1   = {win_q[14][16:0], win_q[14][31:17]} ^ {win_q[14][18:0], win_q[14][31:19]} ^ (win_q[14] >> 10);
  assign w_next = sig1 + win_q[9] + sig0 + win_q[0];

  assign WORD_READY = (state_q == ST_LOAD);
  assign W_VALID    = (state_q == ST_RUN);
  assign BLOCK_DONE = (state_q == ST_DONE);
  assign W_OUT      = win_q[0];
  assign T_IDX      = t_idx_q;
  assign LOAD_CNT   = load_cnt_q;

  always_comb begin
    state_d    = state_q;
    t_idx_d    = t_idx_q;
    load_cnt_d = load_cnt_q;
    for (int k = 0; k < 16; k++) win_d[k] = win_q[k];

    case (state_q)
      ST_LOAD: begin
        if (WORD_VALID) begin
          win_d[load_cnt_q] = WORD_IN;
          load_cnt_d        = load_cnt_q + 4'd1;
          if (load_cnt_q == 4'd15) begin
            state_d = ST_RUN;
            t_idx_d = 6'd0;
          end
        end
      end
      ST_RUN: begin
        if (W_ADVANCE) begin
          for (int k = 0; k < 15; k++) win_d[k] = win_q[k+1];
          win_d[15] = w_next;
          t_idx_d   = t_idx_q + 6'd1;
          if (t_idx_q == 6'd63) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase

    // Abort drops the block but keeps the window contents.
    if (abort_w) begin
      state_d    = ST_LOAD;
      t_idx_d    = 6'd0;
      load_cnt_d = 4'd0;
      for (int k = 0; k < 16; k++) win_d[k] = win_q[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_LOAD;
      t_idx_q    <= 6'd0;
      load_cnt_q <= 4'd0;
      for (int k = 0; k < 16; k++) win_q[k] <= 32'd0;
    end else begin
      state_q    <= state_d;
      t_idx_q    <= t_idx_d;
      load_cnt_q <= load_cnt_d;
      for (int k = 0; k < 16; k++) win_q[k] <= win_d[k];
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: reference W[0..63] per block is queued at load time and popped on each advance.
module tb_sha_msg_schedule;

  typedef struct packed {
    logic [5:0]  t;
    logic [31:0] w;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic [31:0] WORD_IN;
  logic        WORD_VALID;
  logic        WORD_READY;
  logic [31:0] W_OUT;
  logic        W_VALID;
  logic        W_ADVANCE;
  logic [5:0]  T_IDX;
  logic [3:0]  LOAD_CNT;
  logic        BLOCK_DONE;
`ifdef SHA_SCHED_ABORT_EN
  logic        ABORT;
`endif

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];
  logic [31:0] msg   [16];
  logic [31:0] sched [64];

  sha_msg_schedule dut (
    .CLK        (CLK),
    .RESET      (RESET),
`ifdef SHA_SCHED_ABORT_EN
    .ABORT      (ABORT),
`endif
    .WORD_IN    (WORD_IN),
    .WORD_VALID (WORD_VALID),
    .WORD_READY (WORD_READY),
    .W_OUT      (W_OUT),
    .W_VALID    (W_VALID),
    .W_ADVANCE  (W_ADVANCE),
    .T_IDX      (T_IDX),
    .LOAD_CNT   (LOAD_CNT),
    .BLOCK_DONE (BLOCK_DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_sched();
    for (int t = 0; t < 16; t++) sched[t] = msg[t];
    for (int t = 16; t < 64; t++)
      sched[t] = ss1(sched[t-2]) + sched[t-7] + ss0(sched[t-15]) + sched[t-16];
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Loads n words of msg[]; a full block pushes its reference schedule.
  task automatic load_block(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        WORD_VALID = 1'b0;
        WORD_IN    = $urandom;
        W_ADVANCE  = 1'($urandom_range(1));
        tick();
        check("idle_load_cnt", {28'd0, LOAD_CNT}, i);
      end
      check("load_ready", {31'd0, WORD_READY}, 32'd1);
      check("load_cnt", {28'd0, LOAD_CNT}, i);
      check("load_wvalid", {31'd0, W_VALID}, 32'd0);
      WORD_IN    = msg[i];
      WORD_VALID = 1'b1;
      W_ADVANCE  = 1'($urandom_range(1));
      tick();
    end
    if (n == 16) begin
      build_sched();
      for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), sched[t]});
      check("first_w_latency", {31'd0, W_VALID}, 32'd1);
      check("load_cnt_wrap", {28'd0, LOAD_CNT}, 32'd0);
    end
  endtask

  // Drives the RUN phase; returns early (advance low) when T_IDX reaches stop_t.
  task automatic run_block(input int adv_pct, input bit hold_vld, input int stop_t, input bit golden);
    bit          done_seen = 0;
    int          dones = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_w = '0;
    logic [5:0]  prev_t = '0;
    exp_t        e;
    logic [31:0] g;
    bit          gv;
    if (!hold_vld) WORD_VALID = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (W_VALID === 1'b1) begin
        check("run_ready", {31'd0, WORD_READY}, 32'd0);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL run_extra_word: t=%0d with empty scoreboard", T_IDX);
          e = '0;
        end else e = exp_q[0];
        check("w_out", W_OUT, e.w);
        check("t_idx", {26'd0, T_IDX}, {26'd0, e.t});
        if (prev_hold) begin
          check("hold_w_out", W_OUT, prev_w);
          check("hold_t_idx", {26'd0, T_IDX}, {26'd0, prev_t});
        end
        if (golden) begin
          gv = 1;
          case (T_IDX)
            6'd0:             g = 32'h61626380;
            6'd1, 6'd2, 6'd3: g = 32'h00000000;
            6'd15:            g = 32'h00000018;
            6'd16:            g = 32'h61626380;
            6'd17:            g = 32'h000F0000;
            6'd18:            g = 32'h7DA86405;
            6'd19:            g = 32'h600003C6;
            default: begin g = '0; gv = 0; end
          endcase
          if (gv) check("abc_golden", W_OUT, g);
        end
        if (stop_t >= 0 && int'(T_IDX) == stop_t) begin
          W_ADVANCE = 1'b0;
          return;
        end
        W_ADVANCE = ($urandom_range(99) < adv_pct) ? 1'b1 : 1'b0;
        if (W_ADVANCE && exp_q.size() > 0) void'(exp_q.pop_front());
        prev_hold = !W_ADVANCE;
        prev_w    = W_OUT;
        prev_t    = T_IDX;
      end else if (BLOCK_DONE === 1'b1) begin
        dones++;
        done_seen = 1;
        check("done_ready", {31'd0, WORD_READY}, 32'd0);
        check("done_queue_empty", exp_q.size(), 32'd0);
        W_ADVANCE = 1'($urandom_range(1));
      end else if (done_seen) begin
        check("after_done_ready", {31'd0, WORD_READY}, 32'd1);
        check("after_done_t_idx", {26'd0, T_IDX}, 32'd0);
        break;
      end else begin
        n_vec++; n_err++;
        $display("FAIL run_state: neither W_VALID nor BLOCK_DONE (ready=%b)", WORD_READY);
        break;
      end
      if (hold_vld) begin
        WORD_VALID = 1'b1;
        WORD_IN    = $urandom;
      end
      tick();
    end
    check("block_done_pulses", dones, 32'd1);
  endtask

  task automatic abc_msg();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic rand_msg();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
  endtask

  task automatic test_reset();
    RESET = 1'b1; WORD_VALID = 1'b1; W_ADVANCE = 1'b1; WORD_IN = 32'hDEADBEEF;
    tick(); tick();
    check("rst_ready", {31'd0, WORD_READY}, 32'd1);
    check("rst_wvalid", {31'd0, W_VALID}, 32'd0);
    check("rst_done", {31'd0, BLOCK_DONE}, 32'd0);
    check("rst_t_idx", {26'd0, T_IDX}, 32'd0);
    check("rst_load_cnt", {28'd0, LOAD_CNT}, 32'd0);
    check("rst_w_out", W_OUT, 32'd0);
    RESET = 1'b0; WORD_VALID = 1'b0;
    tick();
  endtask

  task automatic test_abc_continuous();
    abc_msg();
    load_block(16, 0);
    run_block(100, 0, -1, 1);
  endtask

  task automatic test_random_advance();
    abc_msg();
    load_block(16, 1);
    run_block(50, 0, -1, 1);
    rand_msg();
    load_block(16, 1);
    run_block(50, 0, -1, 0);
  endtask

  task automatic test_reset_mid_run();
    abc_msg();
    load_block(16, 0);
    run_block(100, 0, 30, 1);
    RESET = 1'b1; W_ADVANCE = 1'b1; WORD_VALID = 1'b1;
    tick();
    RESET = 1'b0; W_ADVANCE = 1'b0; WORD_VALID = 1'b0;
    exp_q.delete();
    check("mid_rst_ready", {31'd0, WORD_READY}, 32'd1);
    check("mid_rst_wvalid", {31'd0, W_VALID}, 32'd0);
    check("mid_rst_load_cnt", {28'd0, LOAD_CNT}, 32'd0);
    check("mid_rst_t_idx", {26'd0, T_IDX}, 32'd0);
    check("mid_rst_w_out", W_OUT, 32'd0);
    rand_msg();
    load_block(16, 1);
    run_block(70, 0, -1, 0);
  endtask

  task automatic test_back_to_back();
    rand_msg();
    load_block(16, 0);
    run_block(100, 1, -1, 0);
    rand_msg();
    load_block(16, 0);
    run_block(80, 1, -1, 0);
    WORD_VALID = 1'b0;
  endtask

`ifdef SHA_SCHED_ABORT_EN
  task automatic test_abort();
    logic [31:0] head;
    ABORT = 1'b0;
    rand_msg();
    load_block(9, 0);
    check("pre_abort_cnt", {28'd0, LOAD_CNT}, 32'd9);
    head = W_OUT;
    ABORT = 1'b1; W_ADVANCE = 1'b1; WORD_VALID = 1'b1; WORD_IN = 32'h12345678;
    tick();
    ABORT = 1'b0; W_ADVANCE = 1'b0; WORD_VALID = 1'b0;
    check("abort_load_cnt", {28'd0, LOAD_CNT}, 32'd0);
    check("abort_load_ready", {31'd0, WORD_READY}, 32'd1);
    check("abort_load_win", W_OUT, head);
    rand_msg();
    load_block(16, 0);
    run_block(100, 0, 40, 0);
    head = W_OUT;
    ABORT = 1'b1; W_ADVANCE = 1'b1; WORD_VALID = 1'b1;
    tick();
    ABORT = 1'b0; W_ADVANCE = 1'b0; WORD_VALID = 1'b0;
    exp_q.delete();
    check("abort_run_ready", {31'd0, WORD_READY}, 32'd1);
    check("abort_run_wvalid", {31'd0, W_VALID}, 32'd0);
    check("abort_run_t_idx", {26'd0, T_IDX}, 32'd0);
    check("abort_run_cnt", {28'd0, LOAD_CNT}, 32'd0);
    check("abort_run_done", {31'd0, BLOCK_DONE}, 32'd0);
    check("abort_run_win", W_OUT, head);
    tick();
    check("abort_run_done2", {31'd0, BLOCK_DONE}, 32'd0);
    abc_msg();
    load_block(16, 0);
    run_block(100, 0, -1, 1);
  endtask
`endif

  initial begin
    RESET = 1'b1; WORD_IN = '0; WORD_VALID = 1'b0; W_ADVANCE = 1'b0;
`ifdef SHA_SCHED_ABORT_EN
    ABORT = 1'b0;
`endif
    #1;
    test_reset();
    test_abc_continuous();
    test_random_advance();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SHA_SCHED_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha_msg_schedule.md
SHA_MSG_SCHEDULE -- requirements
Module: sha_msg_schedule

Interface
REQ-001 SHALL have port CLK, input, 1: sole clock; all state updates on posedge CLK.
REQ-002 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port WORD_IN, input, 32: message word, big-endian, word 0 first.
REQ-004 SHALL have port WORD_VALID, input, 1: WORD_IN holds a valid word.
REQ-005 SHALL have port WORD_READY, output, 1: block accepts a word this cycle.
REQ-006 SHALL have port W_OUT, output, 32: current schedule word W[t].
REQ-007 SHALL have port W_VALID, output, 1: W_OUT and T_IDX are valid.
REQ-008 SHALL have port W_ADVANCE, input, 1: compression round consumed W[t]; this is the compression-timer enable.
REQ-009 SHALL have port T_IDX, output, 6: round index t of W_OUT, 0..63.
REQ-010 SHALL have port LOAD_CNT, output, 4: number of words loaded so far in the current block.
REQ-011 SHALL have port BLOCK_DONE, output, 1: one-cycle pulse after W[63] is consumed.

Function
REQ-012 SHALL implement a three-state FSM: LOAD, RUN, DONE.
REQ-013 SHALL hold a 16-entry x 32-bit window WIN[0..15]; W_OUT SHALL equal WIN[0] combinationally.
REQ-014 LOAD: WORD_READY=1, W_VALID=0; a word transfers when WORD_VALID=1 and WORD_READY=1.
REQ-015 LOAD: each transfer SHALL write WIN[LOAD_CNT] and increment LOAD_CNT.
REQ-016 LOAD: the transfer at LOAD_CNT=15 SHALL move the FSM to RUN with T_IDX=0 and LOAD_CNT wrapping to 0.
REQ-017 RUN: W_VALID=1, WORD_READY=0; WORD_VALID SHALL be ignored.
REQ-018 RUN with W_ADVANCE=1: WIN[k] SHALL load WIN[k+1] for k=0..14, and T_IDX SHALL increment.
REQ-019 RUN with W_ADVANCE=1: WIN[15] SHALL load (s1(WIN[14]) + WIN[9] + s0(WIN[1]) + WIN[0]) mod 2^32.
REQ-020 s0(x) SHALL equal ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-021 s1(x) SHALL equal ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-022 RUN with W_ADVANCE=0: all state SHALL hold and W_OUT SHALL stay stable.
REQ-023 RUN with W_ADVANCE=1 at T_IDX=63: next state SHALL be DONE and T_IDX SHALL wrap to 0.
REQ-024 DONE SHALL last exactly one cycle: BLOCK_DONE=1, W_VALID=0, WORD_READY=0; next state SHALL be LOAD.
REQ-025 W_ADVANCE in LOAD or DONE SHALL be ignored.
REQ-026 Latency: W[0] SHALL be valid the cycle after the 16th word is accepted, and W[t+1] the cycle after each advance.
REQ-027 Throughput: one W per cycle under continuous W_ADVANCE, giving 64 RUN cycles minimum per block.

Reset
REQ-028 RESET=1 SHALL override all other inputs, including a mid-LOAD or mid-RUN block.
REQ-029 On RESET the FSM SHALL go to LOAD with T_IDX=0, LOAD_CNT=0, WORD_READY=1, W_VALID=0, BLOCK_DONE=0 and WIN cleared to 0.

Configuration
REQ-030 Macro SHA_SCHED_ABORT_EN SHALL add input ABORT (1 bit).
REQ-031 With SHA_SCHED_ABORT_EN defined, ABORT=1 in any state SHALL return the FSM to LOAD with T_IDX=0 and LOAD_CNT=0, WIN unchanged and no BLOCK_DONE pulse.
REQ-032 With SHA_SCHED_ABORT_EN defined, ABORT SHALL take priority over W_ADVANCE and WORD_VALID, and RESET SHALL take priority over ABORT.
REQ-033 Without SHA_SCHED_ABORT_EN, the ABORT port SHALL be absent and behaviour SHALL be as in REQ-012..REQ-029.

Verification
REQ-034 "abc" block: load 0x61626380, 14 x 0x00000000, 0x00000018 -> W_OUT sequence t=0..3 is 61626380, 0, 0, 0; t=15 is 00000018.
REQ-035 Same block, continuous advance -> t=16..19 is 61626380, 000F0000, 7DA86405, 600003C6; BLOCK_DONE pulses once after t=63.
REQ-036 W_ADVANCE toggled randomly at 50% -> W_OUT/T_IDX stable while low; sequence matches the REQ-035 golden values.
REQ-037 RESET at T_IDX=30 -> next cycle LOAD, LOAD_CNT=0, WORD_READY=1, W_VALID=0; a new block then loads cleanly.
REQ-038 WORD_VALID held high through RUN/DONE -> no WIN corruption; a back-to-back second block loads starting the cycle after DONE.
REQ-039 (SHA_SCHED_ABORT_EN) ABORT with W_ADVANCE at LOAD_CNT=9 and at T_IDX=40 -> LOAD, counters 0, no BLOCK_DONE.
